alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Button-driven ALU sequencer for a switch/LED board. The operator enters
// operand A, operand B and a 3-bit opcode on the switches, each confirmed by
// one Enter press. The sequencer then spends one cycle in EXEC, latches the
// result and overflow flag, and shows them. While an overflowed result is
// being shown, the display select alternates between the result and the
// overflow indication.
//
// Ports
//   Clk          in   1      single clock, rising edge
//   Reset        in   1      synchronous, active-high
//   SwIn         in   WIDTH  switch data: operand, or opcode in SwIn[2:0]
//   Enter        in   1      debounced, Clk-synchronous push button
//   FuncOut      out  WIDTH  registered ALU result
//   OverflowOut  out  1      registered overflow flag
//   DispSel      out  1      display mux select (1 = overflow, 0 = result)
//   Valid        out  1      high while a completed result is shown
//   StateOut     out  3      current state encoding, for debug LEDs
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int WIDTH        = 4,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] SwIn,
    input  logic             Enter,
    output logic [WIDTH-1:0] FuncOut,
    output logic             OverflowOut,
    output logic             DispSel,
    output logic             Valid,
    output logic [2:0]       StateOut
);

    localparam int MSB   = WIDTH - 1;
    localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_CYCLES - 1);

    typedef enum logic [2:0] {
        s_load_a  = 3'd0,
        s_load_b  = 3'd1,
        s_load_op = 3'd2,
        s_exec    = 3'd3,
        s_show    = 3'd4
    } state_e;

    state_e           state;
    state_e           state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [2:0]       op_reg;

    logic             enter_q;
    logic             enter_armed;
    logic             enter_edge;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    logic [CNT_W-1:0] blink_cnt;

    // -----------------------------------------------------------------------
    // Enter edge detection. enter_armed stays low after reset until Enter has
    // been seen low once, so a button held through reset release cannot
    // masquerade as a fresh press.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            enter_q     <= 1'b0;
            enter_armed <= 1'b0;
        end else begin
            enter_q <= Enter;
            if (!Enter) begin
                enter_armed <= 1'b1;
            end
        end
    end

    assign enter_edge = Enter & ~enter_q & enter_armed;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= s_load_a;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: the default assignment at the top of an always_comb block keeps
    // every path assigned, which is what prevents latch inference.
    always_comb begin
        state_next = state;
        case (state)
            s_load_a:  if (enter_edge) state_next = s_load_b;
            s_load_b:  if (enter_edge) state_next = s_load_op;
            s_load_op: if (enter_edge) state_next = s_exec;
            s_exec:    state_next = s_show;
            s_show:    if (enter_edge) state_next = s_load_a;
            default:   state_next = s_load_a;  // unused codes 5-7 recover
        endcase
    end

    // -----------------------------------------------------------------------
    // ALU. Results are truncated to WIDTH; overflow is signed two's-complement
    // for ADD/SUB and the bit shifted out for SHL.
    // -----------------------------------------------------------------------
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_reg)
            3'b000: begin
                alu_res = a_reg + b_reg;
                alu_ovf = (a_reg[MSB] == b_reg[MSB]) && (alu_res[MSB] != a_reg[MSB]);
            end
            3'b001: begin
                alu_res = a_reg - b_reg;
                alu_ovf = (a_reg[MSB] != b_reg[MSB]) && (alu_res[MSB] != a_reg[MSB]);
            end
            3'b010: alu_res = a_reg & b_reg;
            3'b011: alu_res = a_reg | b_reg;
            3'b100: alu_res = a_reg ^ b_reg;
            3'b101: alu_res = ~a_reg;
            3'b110: begin
                alu_res = {a_reg[MSB-1:0], 1'b0};
                alu_ovf = a_reg[MSB];
            end
            3'b111: alu_res = {1'b0, a_reg[MSB:1]};
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Operand/opcode capture and result registers. The result is loaded on
    // the clock that leaves EXEC and then held until the next EXEC.
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_reg       <= '0;
            b_reg       <= '0;
            op_reg      <= '0;
            FuncOut     <= '0;
            OverflowOut <= 1'b0;
        end else begin
            case (state)
                s_load_a:  if (enter_edge) a_reg  <= SwIn;
                s_load_b:  if (enter_edge) b_reg  <= SwIn;
                s_load_op: if (enter_edge) op_reg <= SwIn[2:0];
                s_exec: begin
                    FuncOut     <= alu_res;
                    OverflowOut <= alu_ovf;
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Blink counter. Runs only while an overflowed result is shown. A press
    // that leaves SHOW wins over a terminal count in the same cycle, so the
    // counter and DispSel clear instead of toggling.
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            blink_cnt <= '0;
            DispSel   <= 1'b0;
        end else if (state == s_show && OverflowOut && !enter_edge) begin
            if (blink_cnt == CNT_MAX) begin
                blink_cnt <= '0;
                DispSel   <= ~DispSel;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end else begin
            blink_cnt <= '0;
            DispSel   <= 1'b0;
        end
    end

    assign Valid    = (state == s_show);
    assign StateOut = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//
// Directed bench for alu_sequencer with WIDTH=4, BLINK_CYCLES=4. Inputs are
// driven 1 ns after the rising edge and outputs are sampled at the same
// point, so every value is stable at the next edge and when it is checked.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

    localparam int WIDTH = 4;

    logic             Clk;
    logic             Reset;
    logic [WIDTH-1:0] SwIn;
    logic             Enter;
    logic [WIDTH-1:0] FuncOut;
    logic             OverflowOut;
    logic             DispSel;
    logic             Valid;
    logic [2:0]       StateOut;

    int n_checks = 0;
    int n_fail   = 0;

    alu_sequencer #(
        .WIDTH       (WIDTH),
        .BLINK_CYCLES(4)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .SwIn       (SwIn),
        .Enter      (Enter),
        .FuncOut    (FuncOut),
        .OverflowOut(OverflowOut),
        .DispSel    (DispSel),
        .Valid      (Valid),
        .StateOut   (StateOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One clean press: Enter high for one edge, then low for one edge.
    task automatic press(input logic [WIDTH-1:0] val);
        SwIn  = val;
        Enter = 1'b1;
        tick();
        Enter = 1'b0;
        tick();
    endtask

    // Full A/B/Op sequence ending in the first cycle of SHOW.
    task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, input logic [3:0] exp_f, input logic exp_o);
        press(a);
        check({tag, "_st_b"}, StateOut, 1);
        press(b);
        check({tag, "_st_op"}, StateOut, 2);
        SwIn  = {1'b0, op};
        Enter = 1'b1;
        tick();
        check({tag, "_st_exec"}, StateOut, 3);
        check({tag, "_valid_exec"}, Valid, 0);
        Enter = 1'b0;
        tick();
        check({tag, "_st_show"}, StateOut, 4);
        check({tag, "_valid"}, Valid, 1);
        check({tag, "_func"}, FuncOut, exp_f);
        check({tag, "_ovf"}, OverflowOut, exp_o);
        check({tag, "_dsel0"}, DispSel, 0);
    endtask

    task automatic go_home(input string tag);
        Enter = 1'b1;
        tick();
        check({tag, "_home_st"}, StateOut, 0);
        check({tag, "_home_valid"}, Valid, 0);
        check({tag, "_home_dsel"}, DispSel, 0);
        Enter = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        tick();
    endtask

    initial begin
        Reset = 1'b1;
        Enter = 1'b0;
        SwIn  = '0;

        // Reset state
        tick();
        tick();
        check("rst_func", FuncOut, 0);
        check("rst_ovf", OverflowOut, 0);
        check("rst_dsel", DispSel, 0);
        check("rst_valid", Valid, 0);
        check("rst_state", StateOut, 0);
        Reset = 1'b0;
        tick();
        check("rst_rel_state", StateOut, 0);

        // 3 + 4 = 7, no overflow, DispSel never moves
        do_op("add37", 4'd3, 4'd4, 3'b000, 4'd7, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("add37_dsel_hold", DispSel, 0);
        end
        go_home("add37");
        check("add37_func_hold", FuncOut, 7);

        // 7 + 1 = 8 with signed overflow; blink period 4 cycles
        do_op("add71", 4'd7, 4'd1, 3'b000, 4'd8, 1'b1);
        tick(); tick(); tick();
        check("blink_t3", DispSel, 0);
        tick();
        check("blink_t4", DispSel, 1);
        tick(); tick(); tick();
        check("blink_t7", DispSel, 1);
        tick();
        check("blink_t8", DispSel, 0);
        tick(); tick(); tick();
        check("blink_t11", DispSel, 0);
        // Press lands on the terminal-count cycle: state change wins
        Enter = 1'b1;
        tick();
        check("collide_state", StateOut, 0);
        check("collide_dsel", DispSel, 0);
        check("collide_func_hold", FuncOut, 8);
        check("collide_ovf_hold", OverflowOut, 1);
        Enter = 1'b0;
        tick();
        check("idle_dsel", DispSel, 0);

        // Subtract wrap and shift-left overflow
        do_op("sub01", 4'd0, 4'd1, 3'b001, 4'd15, 1'b0);
        go_home("sub01");
        do_op("shl8", 4'd8, 4'd0, 3'b110, 4'd0, 1'b1);
        go_home("shl8");

        // Remaining opcodes on A=C, B=A
        do_op("and", 4'hC, 4'hA, 3'b010, 4'h8, 1'b0);
        go_home("and");
        do_op("or", 4'hC, 4'hA, 3'b011, 4'hE, 1'b0);
        go_home("or");
        do_op("xor", 4'hC, 4'hA, 3'b100, 4'h6, 1'b0);
        go_home("xor");
        do_op("not", 4'hC, 4'hA, 3'b101, 4'h3, 1'b0);
        go_home("not");
        do_op("shr", 4'hC, 4'hA, 3'b111, 4'h6, 1'b0);
        go_home("shr");
        do_op("subovf", 4'h8, 4'h1, 3'b001, 4'h7, 1'b1);
        go_home("subovf");

        // Enter held 10 cycles -> exactly one advance
        SwIn  = 4'd9;
        Enter = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("hold_state", StateOut, 1);
        Enter = 1'b0;
        tick();
        check("hold_release_state", StateOut, 1);

        // Reset mid-sequence in LOAD_B after A=5
        do_reset();
        press(4'd5);
        check("midrst_pre_state", StateOut, 1);
        check("midrst_pre_a", dut.a_reg, 5);
        Reset = 1'b1;
        tick();
        check("midrst_state", StateOut, 0);
        check("midrst_a", dut.a_reg, 0);
        check("midrst_valid", Valid, 0);
        check("midrst_func", FuncOut, 0);
        Reset = 1'b0;
        tick();

        // Reset during EXEC: no result load
        press(4'd7);
        press(4'd1);
        SwIn  = 4'd0;
        Enter = 1'b1;
        tick();
        check("execrst_pre", StateOut, 3);
        Enter = 1'b0;
        Reset = 1'b1;
        tick();
        check("execrst_state", StateOut, 0);
        check("execrst_func", FuncOut, 0);
        check("execrst_ovf", OverflowOut, 0);

        // Enter held through reset release: no edge until re-pressed
        Enter = 1'b1;
        tick();
        Reset = 1'b0;
        tick(); tick(); tick();
        check("heldrst_state", StateOut, 0);
        Enter = 1'b0;
        tick();
        check("heldrst_rel_state", StateOut, 0);
        Enter = 1'b1;
        tick();
        check("heldrst_press_state", StateOut, 1);
        Enter = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
